// File: rtl/mna_flit_pkg.sv
// Shared widths, flit field layout and flit type codes for the MNA flit builder.
package mna_flit_pkg;

  localparam int FLIT_W = 37;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int VC_W   = 3;
  localparam int NUM_VC = 8;

  localparam int TYPE_MSB    = 36;
  localparam int TYPE_LSB    = 35;
  localparam int VC_MSB      = 34;
  localparam int VC_LSB      = 32;
  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_LSB = 0;

  localparam logic [1:0] FLIT_HEADER = 2'b01;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;

  typedef struct packed {
    logic [1:0]        ftype;
    logic [VC_W-1:0]   vc;
    logic [DATA_W-1:0] payload;
  } flit_t;

  function automatic flit_t make_flit(input logic [1:0] ftype,
                                      input logic [VC_W-1:0] vc,
                                      input logic [DATA_W-1:0] payload);
    flit_t f;
    f.ftype   = ftype;
    f.vc      = vc;
    f.payload = payload;
    return f;
  endfunction

endpackage

// File: rtl/mna_flit_builder_if.sv
// Transaction-in / flits-out bundle between the AXI-side producer and the flit builder.
interface mna_flit_builder_if;
  import mna_flit_pkg::*;

  logic              build;
  logic [ADDR_W-1:0] addr;
  logic              awrite;
  logic [DATA_W-1:0] wdata;
  logic [NUM_VC-1:0] is_allocatable;
  logic [FLIT_W-1:0] header;
  logic [FLIT_W-1:0] body;
  logic [FLIT_W-1:0] tail;
  logic              flits_valid;
  logic              vc_err;

  modport master (
    output build, addr, awrite, wdata, is_allocatable,
    input  header, body, tail, flits_valid, vc_err
  );

  modport slave (
    input  build, addr, awrite, wdata, is_allocatable,
    output header, body, tail, flits_valid, vc_err
  );

endinterface

// File: rtl/mna_vc_select.sv
// MSB-priority encoder over the router's VC free mask, with empty and multi-bit flags.
module mna_vc_select
  import mna_flit_pkg::*;
(
  input  logic [NUM_VC-1:0] mask,
  output logic [VC_W-1:0]   idx,
  output logic              none,
  output logic              multi
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (mask[i]) idx = VC_W'(i);
    end
  end

  assign none  = (mask == '0);
  assign multi = ((mask & (mask - NUM_VC'(1))) != '0);

endmodule

// File: rtl/mna_flit_builder.sv
// Packs one AXI-Lite transaction into registered header/body/tail NoC flits.
// Optional MNA_FLIT_BUILDER_ONEHOT_CHECK_EN also rejects masks with more than one bit set.
module mna_flit_builder
  import mna_flit_pkg::*;
(
  input logic                clk,
  input logic                rst,
  mna_flit_builder_if.slave  bus
);

  logic [VC_W-1:0] vc_idx;
  logic            vc_none;
  logic            vc_multi;
  logic            reject;

  mna_vc_select u_vc_select (
    .mask  (bus.is_allocatable),
    .idx   (vc_idx),
    .none  (vc_none),
    .multi (vc_multi)
  );

`ifdef MNA_FLIT_BUILDER_ONEHOT_CHECK_EN
  assign reject = vc_none | vc_multi;
`else
  logic unused_multi;
  assign unused_multi = vc_multi;
  assign reject       = vc_none;
`endif

  // Flits only change on an accepted build; pulses clear every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.header      <= '0;
      bus.body        <= '0;
      bus.tail        <= '0;
      bus.flits_valid <= 1'b0;
      bus.vc_err      <= 1'b0;
    end else begin
      bus.flits_valid <= 1'b0;
      bus.vc_err      <= 1'b0;
      if (bus.build) begin
        if (reject) begin
          bus.vc_err <= 1'b1;
        end else begin
          bus.header      <= make_flit(FLIT_HEADER, vc_idx, bus.addr);
          bus.body        <= make_flit(FLIT_BODY, vc_idx,
                                       bus.awrite ? bus.wdata : '0);
          bus.tail        <= make_flit(FLIT_TAIL, vc_idx,
                                       {{(DATA_W-1){1'b0}}, bus.awrite});
          bus.flits_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mna_flit_builder.sv
// Self-checking bench for mna_flit_builder: directed spec cases plus randomized builds against a behavioural model.
module tb_mna_flit_builder;

  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;

  logic [36:0] exp_header, exp_body, exp_tail;
  logic        exp_valid, exp_err;

  mna_flit_builder_if bus ();

  mna_flit_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_vc(input logic [7:0] mask);
    logic [7:0] m;
    int v;
    m = mask;
    v = 0;
    while (m > 8'd1) begin
      m = m >> 1;
      v++;
    end
    return v;
  endfunction

  function automatic bit model_reject(input logic [7:0] mask);
`ifdef MNA_FLIT_BUILDER_ONEHOT_CHECK_EN
    return (mask == 8'd0) || ($countones(mask) > 1);
`else
    return (mask == 8'd0);
`endif
  endfunction

  task automatic model_reset();
    exp_header = '0; exp_body = '0; exp_tail = '0;
    exp_valid = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_step(input bit b, input logic [7:0] mask, input bit aw,
                            input logic [31:0] a, input logic [31:0] wd);
    logic [2:0] v;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (b) begin
      if (model_reject(mask)) begin
        exp_err = 1'b1;
      end else begin
        v = 3'(model_vc(mask));
        exp_header = {2'b01, v, a};
        exp_body   = {2'b00, v, (aw ? wd : 32'd0)};
        exp_tail   = {2'b10, v, 32'(aw)};
        exp_valid  = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, update the model, and return at posedge+1.
  task automatic drive(input bit b, input logic [7:0] mask, input bit aw,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.build          = b;
    bus.is_allocatable = mask;
    bus.awrite         = aw;
    bus.addr           = a;
    bus.wdata          = wd;
    model_step(b, mask, aw, a, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_power_on_reset();
    rst = 1'b1;
    bus.build = 1'b0; bus.is_allocatable = '0; bus.awrite = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    model_reset();
    #2;
    checks_total++;
    if ({bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err} !== '0)
      $display("[TB] FAIL por_outputs: got %h/%h/%h v=%b e=%b expected all zero",
               bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err);
    else checks_passed++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_read_build();
    drive(1'b1, 8'h80, 1'b0, 32'h0, 32'h1);
    checks_total++;
    if (bus.header !== 37'h0F_0000_0000)
      $display("[TB] FAIL read_header: got %h expected %h", bus.header, 37'h0F_0000_0000);
    else checks_passed++;
    checks_total++;
    if (bus.body !== 37'h07_0000_0000)
      $display("[TB] FAIL read_body: got %h expected %h", bus.body, 37'h07_0000_0000);
    else checks_passed++;
    checks_total++;
    if (bus.tail !== 37'h17_0000_0000)
      $display("[TB] FAIL read_tail: got %h expected %h", bus.tail, 37'h17_0000_0000);
    else checks_passed++;
    checks_total++;
    if (bus.flits_valid !== 1'b1 || bus.vc_err !== 1'b0)
      $display("[TB] FAIL read_pulse: got v=%b e=%b expected v=1 e=0", bus.flits_valid, bus.vc_err);
    else checks_passed++;
    drive(1'b0, 8'h80, 1'b0, 32'h0, 32'h1);
    checks_total++;
    if (bus.flits_valid !== 1'b0)
      $display("[TB] FAIL read_pulse_width: got v=%b expected 0", bus.flits_valid);
    else checks_passed++;
  endtask

  task automatic test_write_build();
    drive(1'b1, 8'h01, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    checks_total++;
    if (bus.header !== 37'h08_1000_0004)
      $display("[TB] FAIL write_header: got %h expected %h", bus.header, 37'h08_1000_0004);
    else checks_passed++;
    checks_total++;
    if (bus.body !== 37'h00_DEAD_BEEF)
      $display("[TB] FAIL write_body: got %h expected %h", bus.body, 37'h00_DEAD_BEEF);
    else checks_passed++;
    checks_total++;
    if (bus.tail !== 37'h10_0000_0001)
      $display("[TB] FAIL write_tail: got %h expected %h", bus.tail, 37'h10_0000_0001);
    else checks_passed++;
  endtask

  task automatic test_zero_mask();
    drive(1'b1, 8'h00, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    checks_total++;
    if ({bus.header, bus.body, bus.tail} !== {37'h08_1000_0004, 37'h00_DEAD_BEEF, 37'h10_0000_0001})
      $display("[TB] FAIL zero_mask_hold: got %h/%h/%h expected previous write flits",
               bus.header, bus.body, bus.tail);
    else checks_passed++;
    checks_total++;
    if (bus.vc_err !== 1'b1 || bus.flits_valid !== 1'b0)
      $display("[TB] FAIL zero_mask_pulse: got v=%b e=%b expected v=0 e=1", bus.flits_valid, bus.vc_err);
    else checks_passed++;
    drive(1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    checks_total++;
    if (bus.vc_err !== 1'b0)
      $display("[TB] FAIL zero_mask_pulse_width: got e=%b expected 0", bus.vc_err);
    else checks_passed++;
  endtask

  task automatic test_multi_mask();
    drive(1'b1, 8'h24, 1'b1, 32'hCAFE_0010, 32'h0BAD_F00D);
    checks_total++;
    if ({bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err} !==
        {exp_header, exp_body, exp_tail, exp_valid, exp_err})
      $display("[TB] FAIL mask_24: got %h/%h/%h v=%b e=%b expected %h/%h/%h v=%b e=%b",
               bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err,
               exp_header, exp_body, exp_tail, exp_valid, exp_err);
    else checks_passed++;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'($urandom), 1'($urandom), $urandom, $urandom);
      checks_total++;
      if ({bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err} !==
          {exp_header, exp_body, exp_tail, 2'b00})
        $display("[TB] FAIL idle_hold[%0d]: got %h/%h/%h v=%b e=%b expected %h/%h/%h v=0 e=0",
                 i, bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err,
                 exp_header, exp_body, exp_tail);
      else checks_passed++;
    end
  endtask

  task automatic test_reset_mid_sim();
    drive(1'b1, 8'h10, 1'b1, 32'hA5A5_0000, 32'h5A5A_FFFF);
    #2 rst = 1'b1;
    #1;
    checks_total++;
    if ({bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err} !== '0)
      $display("[TB] FAIL async_reset: got %h/%h/%h v=%b e=%b expected all zero",
               bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err);
    else checks_passed++;
    bus.build = 1'b1; bus.is_allocatable = 8'hFF; bus.addr = 32'h1111_2222;
    @(posedge clk);
    #1;
    checks_total++;
    if ({bus.header, bus.flits_valid} !== '0)
      $display("[TB] FAIL reset_beats_build: got header=%h v=%b expected 0", bus.header, bus.flits_valid);
    else checks_passed++;
    bus.build = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mask;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       mask = 8'h00;
        1:       mask = 8'(1 << $urandom_range(0, 7));
        default: mask = 8'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), mask, 1'($urandom), $urandom, $urandom);
      checks_total++;
      if ({bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err} !==
          {exp_header, exp_body, exp_tail, exp_valid, exp_err})
        $display("[TB] FAIL random[%0d] mask=%h: got %h/%h/%h v=%b e=%b expected %h/%h/%h v=%b e=%b",
                 i, mask, bus.header, bus.body, bus.tail, bus.flits_valid, bus.vc_err,
                 exp_header, exp_body, exp_tail, exp_valid, exp_err);
      else checks_passed++;
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    test_power_on_reset();
    test_read_build();
    test_write_build();
    test_zero_mask();
    test_multi_mask();
    test_idle_hold();
    test_reset_mid_sim();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
